// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, default protection bits and
// the state encoding of the single-outstanding master FSM.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    StIdle,  // waiting for a command
    StWr,    // AW and W channels in progress
    StWrB,   // waiting for the write response
    StRdA,   // read address in progress
    StRdR,   // waiting for read data
    StRsp    // response held for the requester
  } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master. Converts a command/response interface
// into AXI-Lite reads and writes, one transaction in flight at a time.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_*                  command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                  response out (valid/ready, write echo, rdata, resp)
//   busy                   high whenever the FSM is not idle
//   M_AXI_*                AXI-Lite master channels AW, W, B, AR, R
//
// Build option:
//   AXI_LITE_MASTER_ALIGN_CHECK_EN  when defined, commands with addr[1:0] != 0
//                                   are answered with SLVERR without any bus
//                                   transaction.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,

  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;
  logic                      awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                      aw_done_q, w_done_q;
  logic                      rsp_valid_q, rsp_write_q, busy_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic [1:0]                rsp_resp_q;

  logic aw_hs, w_hs;
  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;

  // Only combinational output: lets a command be taken in any idle cycle.
  assign cmd_ready = (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            wstrb_q     <= cmd_wstrb;
            rsp_write_q <= cmd_write;
            busy_q      <= 1'b1;
`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
            if (cmd_addr[1:0] != 2'b00) begin
              state_q     <= StRsp;
              rsp_valid_q <= 1'b1;
              rsp_resp_q  <= RESP_SLVERR;
              rsp_rdata_q <= '0;
            end else
`endif
            if (cmd_write) begin
              state_q   <= StWr;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              state_q   <= StRdA;
              arvalid_q <= 1'b1;
            end
          end
        end
        StWr: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // Include this cycle's handshakes so same-cycle completion advances.
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            state_q  <= StWrB;
            bready_q <= 1'b1;
          end
        end
        StWrB: begin
          if (M_AXI_BVALID) begin
            rsp_resp_q  <= M_AXI_BRESP;
            rsp_rdata_q <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRdA: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdR;
          end
        end
        StRdR: begin
          if (M_AXI_RVALID) begin
            rsp_rdata_q <= M_AXI_RDATA;
            rsp_resp_q  <= M_AXI_RRESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = busy_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master. Slave-side handshakes are driven by hand
// cycle by cycle; all expected values are written in directly.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in an idle cycle; returns in cycle T+1.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, then consume it.
  task automatic finish_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!rsp_valid) check("rsp_timeout", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 1'b0);
    check("idle_after_rsp", cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    #12;
    // Reset state
    check("rst_awvalid", M_AXI_AWVALID, 1'b0);
    check("rst_wvalid", M_AXI_WVALID, 1'b0);
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_bready", M_AXI_BREADY, 1'b0);
    check("rst_rready", M_AXI_RREADY, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_awaddr", M_AXI_AWADDR, 32'h0);
    rst_n = 1'b1;
    tick();

    // Zero-wait write, same-cycle AW/W completion
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
    send_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF);
    check("w1_awvalid_t1", M_AXI_AWVALID, 1'b1);
    check("w1_wvalid_t1", M_AXI_WVALID, 1'b1);
    check("w1_awaddr", M_AXI_AWADDR, 32'h0000_1004);
    check("w1_wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
    check("w1_wstrb", M_AXI_WSTRB, 4'hF);
    check("w1_awprot", M_AXI_AWPROT, 3'b000);
    check("w1_busy", busy, 1'b1);
    check("w1_cmd_ready_busy", cmd_ready, 1'b0);
    tick();
    check("w1_awvalid_t2", M_AXI_AWVALID, 1'b0);
    check("w1_wvalid_t2", M_AXI_WVALID, 1'b0);
    check("w1_bready_t2", M_AXI_BREADY, 1'b1);
    check("w1_rsp_valid_t2", rsp_valid, 1'b0);
    tick();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    check("w1_rsp_valid_t3", rsp_valid, 1'b1);
    check("w1_rsp_resp", rsp_resp, 2'b00);
    check("w1_rsp_write", rsp_write, 1'b1);
    check("w1_rsp_rdata", rsp_rdata, 32'h0);
    check("w1_bready_t3", M_AXI_BREADY, 1'b0);
    finish_rsp();
    check("w1_busy_done", busy, 1'b0);

    // Read with ARREADY delayed 3 cycles
    send_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check("r1_arvalid_held", M_AXI_ARVALID, 1'b1);
      check("r1_araddr_held", M_AXI_ARADDR, 32'h0000_2000);
      if (i == 3) M_AXI_ARREADY = 1'b1;
      tick();
    end
    M_AXI_ARREADY = 1'b0;
    check("r1_arvalid_drop", M_AXI_ARVALID, 1'b0);
    check("r1_rready", M_AXI_RREADY, 1'b1);
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h1234_5678; M_AXI_RRESP = 2'b00;
    tick();
    M_AXI_RVALID = 1'b0;
    check("r1_rsp_valid", rsp_valid, 1'b1);
    check("r1_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("r1_rsp_write", rsp_write, 1'b0);
    check("r1_rready_drop", M_AXI_RREADY, 1'b0);
    finish_rsp();

    // W completes two cycles before AW
    send_cmd(1'b1, 32'h0000_1008, 32'h0000_00AA, 4'h1);
    M_AXI_WREADY = 1'b1;
    tick();
    M_AXI_WREADY = 1'b0;
    check("wa_wvalid_drop", M_AXI_WVALID, 1'b0);
    check("wa_awvalid_hold", M_AXI_AWVALID, 1'b1);
    check("wa_bready_wait1", M_AXI_BREADY, 1'b0);
    tick();
    check("wa_awvalid_hold2", M_AXI_AWVALID, 1'b1);
    check("wa_bready_wait2", M_AXI_BREADY, 1'b0);
    M_AXI_AWREADY = 1'b1;
    tick();
    M_AXI_AWREADY = 1'b0;
    check("wa_awvalid_drop", M_AXI_AWVALID, 1'b0);
    check("wa_bready", M_AXI_BREADY, 1'b1);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b10;
    tick();
    M_AXI_BVALID = 1'b0;
    check("wa_rsp_slverr", rsp_resp, 2'b10);
    finish_rsp();

    // AW completes two cycles before W
    send_cmd(1'b1, 32'h0000_100C, 32'h5555_0000, 4'hC);
    M_AXI_AWREADY = 1'b1;
    tick();
    M_AXI_AWREADY = 1'b0;
    check("aw_awvalid_drop", M_AXI_AWVALID, 1'b0);
    check("aw_wvalid_hold", M_AXI_WVALID, 1'b1);
    check("aw_wdata_hold", M_AXI_WDATA, 32'h5555_0000);
    check("aw_bready_wait1", M_AXI_BREADY, 1'b0);
    tick();
    check("aw_bready_wait2", M_AXI_BREADY, 1'b0);
    M_AXI_WREADY = 1'b1;
    tick();
    M_AXI_WREADY = 1'b0;
    check("aw_wvalid_drop", M_AXI_WVALID, 1'b0);
    check("aw_bready", M_AXI_BREADY, 1'b1);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
    tick();
    M_AXI_BVALID = 1'b0;
    finish_rsp();

    // DECERR write, then an immediate read with SLVERR
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b11;
    send_cmd(1'b1, 32'h0000_3000, 32'h0000_0001, 4'hF);
    tick();
    tick();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    check("de_rsp_resp", rsp_resp, 2'b11);
    finish_rsp();
    M_AXI_ARREADY = 1'b1;
    send_cmd(1'b0, 32'h0000_3004, 32'h0, 4'h0);
    check("de_next_arvalid", M_AXI_ARVALID, 1'b1);
    check("de_next_araddr", M_AXI_ARADDR, 32'h0000_3004);
    tick();
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hCAFE_0001; M_AXI_RRESP = 2'b10;
    tick();
    M_AXI_RVALID = 1'b0;
    check("se_rsp_resp", rsp_resp, 2'b10);
    check("se_rsp_rdata", rsp_rdata, 32'hCAFE_0001);

    // Back-pressure on the response for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
      check("bp_rsp_resp", rsp_resp, 2'b10);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    finish_rsp();

    // Asynchronous reset while waiting in WR_B
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    send_cmd(1'b1, 32'h0000_4000, 32'h0000_00FF, 4'hF);
    tick();
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
    check("ar_bready_before", M_AXI_BREADY, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_bready", M_AXI_BREADY, 1'b0);
    check("ar_awvalid", M_AXI_AWVALID, 1'b0);
    check("ar_wvalid", M_AXI_WVALID, 1'b0);
    check("ar_arvalid", M_AXI_ARVALID, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_cmd_ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Misaligned read
    send_cmd(1'b0, 32'h0000_0002, 32'h0, 4'h0);
`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
    check("al_no_arvalid", M_AXI_ARVALID, 1'b0);
    check("al_rsp_valid_t1", rsp_valid, 1'b1);
    check("al_rsp_resp", rsp_resp, 2'b10);
    check("al_rsp_rdata", rsp_rdata, 32'h0);
`else
    check("al_arvalid", M_AXI_ARVALID, 1'b1);
    check("al_araddr", M_AXI_ARADDR, 32'h0000_0002);
    M_AXI_ARREADY = 1'b1;
    tick();
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h0BAD_F00D; M_AXI_RRESP = 2'b00;
    tick();
    M_AXI_RVALID = 1'b0;
    check("al_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
`endif
    finish_rsp();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
